imem_arbiter: RTL

Two-requester arbiter and access sequencer for the single-ported instruction ROM. It shares the ROM between the core fetch stage (if_*) and a debug/loader read port (dbg_*). A grant/rvalid handshake and a programmable wait-state counter model ROM access latency. The block sits between the fetch stage and the instruction ROM, which is driven only through mem_addr_o and mem_data_i.

---
 rtl/imem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction ROM between the fetch
// stage (if_*) and a debug/loader read port (dbg_*). Round-robin arbitration,
// a grant/rvalid handshake and a LATENCY-cycle wait counter for the ROM.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   if_req_i / if_addr_i         fetch request and byte address
//   if_gnt_o                     fetch accepted this cycle (combinational)
//   if_rvalid_o / if_rdata_o     fetch response pulse and held read data
//   dbg_req_i / dbg_addr_i       debug request and byte address
//   dbg_gnt_o                    debug accepted this cycle (combinational)
//   dbg_rvalid_o / dbg_rdata_o   debug response pulse and held read data
//   mem_addr_o                   address driven to the ROM (registered)
//   mem_data_i                   combinational ROM read data
module imem_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int unsigned CNT_W = 4;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("imem_arbiter: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    state_t              state_q,      state_d;
    owner_t              owner_q,      owner_d;
    owner_t              last_q,       last_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q,  dbg_rdata_d;
    logic                if_rvalid_q,  if_rvalid_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;
    logic                gnt_if,       gnt_dbg;

    // State and datapath registers; reset discards any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_q       <= OWN_DBG;
            addr_q       <= '0;
            cnt_q        <= '0;
            if_rdata_q   <= '0;
            dbg_rdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            if_rdata_q   <= if_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            if_rvalid_q  <= if_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    // Next-state, arbitration and capture logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        if_rdata_d   = if_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        if_rvalid_d  = 1'b0;
        dbg_rvalid_d = 1'b0;
        gnt_if       = 1'b0;
        gnt_dbg      = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                // On a tie the port that did not win last time is served.
                if (if_req_i && (!dbg_req_i || last_q == OWN_DBG)) begin
                    gnt_if = 1'b1;
                end else if (dbg_req_i) begin
                    gnt_dbg = 1'b1;
                end

                if (gnt_if) begin
                    addr_d  = if_addr_i;
                    owner_d = OWN_IF;
                    last_d  = OWN_IF;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end else if (gnt_dbg) begin
                    addr_d  = dbg_addr_i;
                    owner_d = OWN_DBG;
                    last_d  = OWN_DBG;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d  = mem_data_i;
                        if_rvalid_d = 1'b1;
                    end else begin
                        dbg_rdata_d  = mem_data_i;
                        dbg_rvalid_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_gnt_o     = gnt_if;
    assign dbg_gnt_o    = gnt_dbg;
    assign if_rvalid_o  = if_rvalid_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign if_rdata_o   = if_rdata_q;
    assign dbg_rdata_o  = dbg_rdata_q;
    assign mem_addr_o   = addr_q;

endmodule
